lpr_char_scheduler: RTL and testbench
=====================================

LPR_CHAR_SCHEDULER -- requirements
Module: lpr_char_scheduler

Interface
REQ-001 The module SHALL have the parameter NUM_CHARS, default 8: number of plate character slots.
REQ-002 The module SHALL have the parameter NUM_LANES, default 2: number of parallel recognizer lanes; NUM_CHARS SHALL be a multiple of NUM_LANES.
REQ-003 The module SHALL have the parameter CODE_W, default 40: character code width.
REQ-004 The module SHALL have the parameter COORD_W, default 12: coordinate width.
REQ-005 Derived values SHALL be G = NUM_CHARS/NUM_LANES groups and GRP_W = max(1, clog2(G)).
REQ-006 The module SHALL have the ports pixelclk (in, 1) and reset_n (in, 1); one clock; reset asynchronous, active-low.
REQ-007 The module SHALL have i_vs (in, 1): frame vsync, active high.
REQ-008 The module SHALL have i_enable (in, 1): scheduling enable.
REQ-009 The module SHALL have i_bounds_valid (in, 1): the segmentation boundaries are valid.
REQ-010 The module SHALL have i_hcount_l_bus and i_hcount_r_bus (in, NUM_CHARS*COORD_W): per-slot left/right columns, slot k at [k*COORD_W +: COORD_W].
REQ-011 The module SHALL have i_vcount_l and i_vcount_r (in, COORD_W): plate top/bottom rows.
REQ-012 The module SHALL have i_lane_char (in, NUM_LANES*CODE_W): recognizer results, lane j at [j*CODE_W +: CODE_W].
REQ-013 The module SHALL have o_lane_hcount_l and o_lane_hcount_r (out, NUM_LANES*COORD_W), o_lane_vcount_l and o_lane_vcount_r (out, COORD_W): windows for the recognizers.
REQ-014 The module SHALL have o_lane_active (out, 1): the lane windows are meaningful this frame.
REQ-015 The module SHALL have o_group (out, GRP_W): the group currently being recognised.
REQ-016 The module SHALL have o_char_bus (out, NUM_CHARS*CODE_W) and o_char_valid (out, NUM_CHARS): stored codes, slot k at [k*CODE_W +: CODE_W].
REQ-017 The module SHALL have o_plate_done (out, 1): single-cycle pulse at the end of a pass.
REQ-018 The module SHALL have o_plate_stable (out, 1): two consecutive passes matched.

Function
REQ-019 An event SHALL be the rising pixelclk edge at which i_vs samples 1 and the registered vs_r is 0; all state and outputs SHALL update only on events; the latency is zero cycles from the event edge.
REQ-020 The FSM SHALL have two states, IDLE and RUN.
REQ-021 IDLE, at an event with i_enable=1 and i_bounds_valid=1: snapshot all hcount/vcount inputs; set group=0; drive the group-0 windows; set o_lane_active=1; go to RUN.
REQ-022 In IDLE, o_lane_active SHALL be 0 and the lane window outputs SHALL hold their last values.
REQ-023 Lane j in group g SHALL serve slot g*NUM_LANES+j, using snapshot values only (live inputs do not affect a pass in progress).
REQ-024 RUN, at an event with i_enable=1: write i_lane_char lane j into slot group*NUM_LANES+j and set its valid bit.
REQ-025 RUN write with group<G-1: group SHALL increment and the windows SHALL switch to the new group.
REQ-026 RUN write with group=G-1: pulse o_plate_done for that one cycle; set group=0; if i_bounds_valid=1, re-snapshot and stay in RUN, else go to IDLE with o_lane_active=0.
REQ-027 RUN, at an event with i_enable=0: discard the results; go to IDLE; o_char_bus and o_char_valid SHALL be retained.
REQ-028 An i_enable or i_bounds_valid change between events SHALL have no effect.

Reset
REQ-029 Reset SHALL asynchronously force: state=IDLE, group=0, vs_r=1 (a vsync already high at reset release is not an event), and all outputs 0.
REQ-030 A reset asserted mid-pass SHALL discard all partial results; the next pass SHALL start from IDLE.

Configuration
REQ-031 With macro LPR_STABLE_CHECK_EN defined: each slot write SHALL compare the new code with the stored code and require that slot's valid bit to be already set; any mismatch clears a pass_match flag that is set at each pass start.
REQ-032 With LPR_STABLE_CHECK_EN defined, at pass end o_plate_stable SHALL take pass_match and hold until the next pass end; entering IDLE SHALL clear it.
REQ-033 Without LPR_STABLE_CHECK_EN, o_plate_stable SHALL be constant 0 and no compare logic SHALL be built.

Verification (NUM_CHARS=8, NUM_LANES=2)
REQ-034 Reset, then i_enable=1, bounds_valid=1, and 5 events with lane results {A1,A2}..{D1,D2} -> o_group 0,1,2,3,0; slots 0..7 = A1..D2; o_char_valid=8'hFF; o_plate_done pulses once, at event 5.
REQ-035 Two identical passes -> o_plate_stable=1 after the second pass end; a third pass with slot 5 changed -> o_plate_stable=0 at its end (macro defined); the macro undefined -> o_plate_stable is always 0.
REQ-036 Change i_hcount_l_bus slot 2 from 100 to 300 mid-pass -> lane-0 window stays 100 until the next pass snapshot.
REQ-037 i_enable=0 at the event closing group 1 -> slots 2,3 unchanged, IDLE, o_lane_active=0, earlier codes retained.
REQ-038 reset_n low for 3 cycles during group 2 -> o_char_valid=0 and o_group=0; i_vs high at reset release -> no event until i_vs falls and rises again.

Source files
------------

// File: rtl/lpr_char_scheduler.sv
// lpr_char_scheduler
// Sequences plate character slots through a small set of parallel recognizer
// lanes, one group of NUM_LANES slots per vsync frame. It snapshots the
// segmentation boundaries at the start of each pass and stores the returned
// character codes. It also pulses o_plate_done when the last group is written.
// Optional feature: define LPR_STABLE_CHECK_EN to compare each pass with the
// previous one and report o_plate_stable. Without it, o_plate_stable is tied to 0.
module lpr_char_scheduler #(
    parameter int NUM_CHARS = 8,
    parameter int NUM_LANES = 2,
    parameter int CODE_W    = 40,
    parameter int COORD_W   = 12,
    localparam int G        = NUM_CHARS / NUM_LANES,
    localparam int GRP_W    = (G > 1) ? $clog2(G) : 1
) (
    input  logic                           pixelclk,
    input  logic                           reset_n,
    input  logic                           i_vs,
    input  logic                           i_enable,
    input  logic                           i_bounds_valid,
    input  logic [NUM_CHARS*COORD_W-1:0]   i_hcount_l_bus,
    input  logic [NUM_CHARS*COORD_W-1:0]   i_hcount_r_bus,
    input  logic [COORD_W-1:0]             i_vcount_l,
    input  logic [COORD_W-1:0]             i_vcount_r,
    input  logic [NUM_LANES*CODE_W-1:0]    i_lane_char,
    output logic [NUM_LANES*COORD_W-1:0]   o_lane_hcount_l,
    output logic [NUM_LANES*COORD_W-1:0]   o_lane_hcount_r,
    output logic [COORD_W-1:0]             o_lane_vcount_l,
    output logic [COORD_W-1:0]             o_lane_vcount_r,
    output logic                           o_lane_active,
    output logic [GRP_W-1:0]               o_group,
    output logic [NUM_CHARS*CODE_W-1:0]    o_char_bus,
    output logic [NUM_CHARS-1:0]           o_char_valid,
    output logic                           o_plate_done,
    output logic                           o_plate_stable
);

    typedef enum logic {IDLE, RUN} state_t;

    // Window bus width and code bus width for one group of lanes
    localparam int WIN_W = NUM_LANES * COORD_W;
    localparam int GCW   = NUM_LANES * CODE_W;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(G - 1);

    state_t                 state_reg;
    logic                   vs_reg;
    logic [GRP_W-1:0]       group_reg;
    logic [GRP_W-1:0]       group_inc;
    logic [WIN_W-1:0]       hl_snap_reg [G];
    logic [WIN_W-1:0]       hr_snap_reg [G];
    logic [GCW-1:0]         char_reg [G];
    logic [NUM_LANES-1:0]   valid_reg [G];

    logic vs_event;
    logic pass_start;
    logic slot_wr;
    logic pass_end;
    logic restart;
    logic abort;

    // Every action is tied to a vsync rising edge; vs_reg resets high so a
    // vsync already asserted at reset release does not count as an edge.
    assign vs_event   = i_vs & ~vs_reg;
    assign group_inc  = group_reg + 1'b1;
    assign pass_start = vs_event && (state_reg == IDLE) && i_enable && i_bounds_valid;
    assign slot_wr    = vs_event && (state_reg == RUN) && i_enable;
    assign abort      = vs_event && (state_reg == RUN) && !i_enable;
    assign pass_end   = slot_wr && (group_reg == LAST_GRP);
    assign restart    = pass_end && i_bounds_valid;

    assign o_group = group_reg;

    // Main sequencer: state, group counter, lane windows and done pulse
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            vs_reg          <= 1'b1;
            group_reg       <= '0;
            o_lane_hcount_l <= '0;
            o_lane_hcount_r <= '0;
            o_lane_vcount_l <= '0;
            o_lane_vcount_r <= '0;
            o_lane_active   <= 1'b0;
            o_plate_done    <= 1'b0;
        end else begin
            vs_reg       <= i_vs;
            o_plate_done <= 1'b0;
            if (pass_start || restart) begin
                // Group 0 windows come straight from the live inputs being snapshotted
                state_reg       <= RUN;
                group_reg       <= '0;
                o_lane_hcount_l <= i_hcount_l_bus[WIN_W-1:0];
                o_lane_hcount_r <= i_hcount_r_bus[WIN_W-1:0];
                o_lane_vcount_l <= i_vcount_l;
                o_lane_vcount_r <= i_vcount_r;
                o_lane_active   <= 1'b1;
                o_plate_done    <= restart;
            end else if (pass_end) begin
                state_reg     <= IDLE;
                group_reg     <= '0;
                o_lane_active <= 1'b0;
                o_plate_done  <= 1'b1;
            end else if (slot_wr) begin
                group_reg       <= group_inc;
                o_lane_hcount_l <= hl_snap_reg[group_inc];
                o_lane_hcount_r <= hr_snap_reg[group_inc];
            end else if (abort) begin
                state_reg     <= IDLE;
                group_reg     <= '0;
                o_lane_active <= 1'b0;
            end
        end
    end

    // Boundary snapshot, grouped so each entry is one group's lane windows
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < G; g++) begin
                hl_snap_reg[g] <= '0;
                hr_snap_reg[g] <= '0;
            end
        end else if (pass_start || restart) begin
            for (int g = 0; g < G; g++) begin
                hl_snap_reg[g] <= i_hcount_l_bus[g*WIN_W +: WIN_W];
                hr_snap_reg[g] <= i_hcount_r_bus[g*WIN_W +: WIN_W];
            end
        end
    end

    // Result store: the current group's lanes land in their slots together
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < G; g++) begin
                char_reg[g]  <= '0;
                valid_reg[g] <= '0;
            end
        end else if (slot_wr) begin
            char_reg[group_reg]  <= i_lane_char;
            valid_reg[group_reg] <= '1;
        end
    end

    generate
        for (genvar gi = 0; gi < G; gi++) begin : g_out
            assign o_char_bus[gi*GCW +: GCW]               = char_reg[gi];
            assign o_char_valid[gi*NUM_LANES +: NUM_LANES] = valid_reg[gi];
        end
    endgenerate

`ifdef LPR_STABLE_CHECK_EN
    logic                 pass_match_reg;
    logic [NUM_LANES-1:0] lane_match;

    // A lane matches only if its slot already held the same code
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_match
            assign lane_match[gi] = valid_reg[group_reg][gi] &&
                (char_reg[group_reg][gi*CODE_W +: CODE_W] == i_lane_char[gi*CODE_W +: CODE_W]);
        end
    endgenerate

    // Pass-to-pass stability: accumulate matches, publish at pass end, clear in IDLE
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            pass_match_reg <= 1'b0;
            o_plate_stable <= 1'b0;
        end else if (restart) begin
            o_plate_stable <= pass_match_reg & (&lane_match);
            pass_match_reg <= 1'b1;
        end else if (pass_end || abort) begin
            o_plate_stable <= 1'b0;
        end else if (pass_start) begin
            pass_match_reg <= 1'b1;
        end else if (slot_wr) begin
            pass_match_reg <= pass_match_reg & (&lane_match);
        end
    end
`else
    assign o_plate_stable = 1'b0;
`endif

endmodule

// File: tb/tb_lpr_char_scheduler.sv
// Directed testbench for lpr_char_scheduler (NUM_CHARS=8, NUM_LANES=2).
// Expected o_plate_stable values follow LPR_STABLE_CHECK_EN.
module tb_lpr_char_scheduler;
    localparam int NC = 8;
    localparam int NL = 2;
    localparam int CW = 40;
    localparam int XW = 12;
    localparam int GW = 2;
`ifdef LPR_STABLE_CHECK_EN
    localparam bit STB = 1'b1;
`else
    localparam bit STB = 1'b0;
`endif

    logic              pixelclk = 1'b0;
    logic              reset_n = 1'b0;
    logic              i_vs = 1'b0;
    logic              i_enable = 1'b0;
    logic              i_bounds_valid = 1'b0;
    logic [NC*XW-1:0]  i_hcount_l_bus = '0;
    logic [NC*XW-1:0]  i_hcount_r_bus = '0;
    logic [XW-1:0]     i_vcount_l = '0;
    logic [XW-1:0]     i_vcount_r = '0;
    logic [NL*CW-1:0]  i_lane_char = '0;
    logic [NL*XW-1:0]  o_lane_hcount_l;
    logic [NL*XW-1:0]  o_lane_hcount_r;
    logic [XW-1:0]     o_lane_vcount_l;
    logic [XW-1:0]     o_lane_vcount_r;
    logic              o_lane_active;
    logic [GW-1:0]     o_group;
    logic [NC*CW-1:0]  o_char_bus;
    logic [NC-1:0]     o_char_valid;
    logic              o_plate_done;
    logic              o_plate_stable;

    lpr_char_scheduler #(.NUM_CHARS(NC), .NUM_LANES(NL), .CODE_W(CW), .COORD_W(XW)) dut (
        .pixelclk(pixelclk), .reset_n(reset_n), .i_vs(i_vs), .i_enable(i_enable),
        .i_bounds_valid(i_bounds_valid), .i_hcount_l_bus(i_hcount_l_bus),
        .i_hcount_r_bus(i_hcount_r_bus), .i_vcount_l(i_vcount_l), .i_vcount_r(i_vcount_r),
        .i_lane_char(i_lane_char), .o_lane_hcount_l(o_lane_hcount_l),
        .o_lane_hcount_r(o_lane_hcount_r), .o_lane_vcount_l(o_lane_vcount_l),
        .o_lane_vcount_r(o_lane_vcount_r), .o_lane_active(o_lane_active), .o_group(o_group),
        .o_char_bus(o_char_bus), .o_char_valid(o_char_valid), .o_plate_done(o_plate_done),
        .o_plate_stable(o_plate_stable)
    );

    always #5 pixelclk = ~pixelclk;

    int checks = 0;
    int failures = 0;
    int ev_count = 0;
    logic [CW-1:0] exp_char [NC];
    logic [NC-1:0] exp_valid;
    logic [CW-1:0] lane_code [NL];

    function automatic logic [CW-1:0] code(input int p, input int s);
        return {8'hC0, 16'(p), 16'(s)};
    endfunction

    function automatic logic [NC*CW-1:0] exp_bus();
        logic [NC*CW-1:0] b;
        for (int k = 0; k < NC; k++) b[k*CW +: CW] = exp_char[k];
        return b;
    endfunction

    // Hand-chosen boundaries: left column of slot k is 80+10k (slot 2 = 100)
    function automatic logic [XW-1:0] hl(input int k);
        return XW'(80 + 10 * k);
    endfunction

    function automatic logic [NL*XW-1:0] win_l(input int g);
        return {hl(2*g+1), hl(2*g)};
    endfunction

    function automatic logic [NL*XW-1:0] win_r(input int g);
        return {hl(2*g+1) + 12'd5, hl(2*g) + 12'd5};
    endfunction

    task automatic set_bounds();
        for (int k = 0; k < NC; k++) begin
            i_hcount_l_bus[k*XW +: XW] = hl(k);
            i_hcount_r_bus[k*XW +: XW] = hl(k) + 12'd5;
        end
        i_vcount_l = 12'd20;
        i_vcount_r = 12'd40;
    endtask

    task automatic clear_model();
        for (int k = 0; k < NC; k++) exp_char[k] = '0;
        exp_valid = '0;
    endtask

    // Present lane results for group g of pass p; alt5 substitutes slot 5's code
    task automatic load_lanes(input int g, input int p, input bit alt5);
        for (int j = 0; j < NL; j++) begin
            int s;
            s = 2*g + j;
            lane_code[j] = (alt5 && s == 5) ? code(3, s) : code(p, s);
            i_lane_char[j*CW +: CW] = lane_code[j];
        end
    endtask

    task automatic commit(input int g);
        for (int j = 0; j < NL; j++) begin
            exp_char[2*g + j] = lane_code[j];
            exp_valid[2*g + j] = 1'b1;
        end
    endtask

    // One vsync rising edge; returns 1 time unit after the event edge
    task automatic ev();
        @(negedge pixelclk);
        i_vs = 1'b0;
        @(negedge pixelclk);
        i_vs = 1'b1;
        @(posedge pixelclk);
        #1;
        ev_count++;
        $display("ev %0d: en=%0b bv=%0b group=%0d active=%0b done=%0b stable=%0b valid=%h",
                 ev_count, i_enable, i_bounds_valid, o_group, o_lane_active,
                 o_plate_done, o_plate_stable, o_char_valid);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_vs = 1'b0;
        i_enable = 1'b0;
        i_bounds_valid = 1'b0;
        set_bounds();
        clear_model();
        repeat (3) @(posedge pixelclk);
        #1;
        checks++; if (o_char_valid !== '0) begin failures++; $display("FAIL reset_valid: got %h want 0", o_char_valid); end
        checks++; if (o_char_bus !== '0) begin failures++; $display("FAIL reset_bus: got %h want 0", o_char_bus); end
        checks++; if (o_group !== 2'd0) begin failures++; $display("FAIL reset_group: got %0d want 0", o_group); end
        checks++; if (o_lane_active !== 1'b0) begin failures++; $display("FAIL reset_active: got %b want 0", o_lane_active); end
        checks++; if (o_plate_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", o_plate_done); end
        checks++; if (o_plate_stable !== 1'b0) begin failures++; $display("FAIL reset_stable: got %b want 0", o_plate_stable); end
        checks++; if ({o_lane_hcount_l, o_lane_hcount_r, o_lane_vcount_l, o_lane_vcount_r} !== '0) begin
            failures++; $display("FAIL reset_windows: got %h %h %h %h want 0",
                                 o_lane_hcount_l, o_lane_hcount_r, o_lane_vcount_l, o_lane_vcount_r);
        end
        @(negedge pixelclk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic_pass();
        i_enable = 1'b1;
        i_bounds_valid = 1'b1;
        ev();
        checks++; if (o_lane_active !== 1'b1) begin failures++; $display("FAIL start_active: got %b want 1", o_lane_active); end
        checks++; if (o_group !== 2'd0) begin failures++; $display("FAIL start_group: got %0d want 0", o_group); end
        checks++; if (o_lane_hcount_l !== win_l(0)) begin failures++; $display("FAIL start_win_l: got %h want %h", o_lane_hcount_l, win_l(0)); end
        checks++; if (o_lane_hcount_r !== win_r(0)) begin failures++; $display("FAIL start_win_r: got %h want %h", o_lane_hcount_r, win_r(0)); end
        checks++; if (o_lane_vcount_l !== 12'd20 || o_lane_vcount_r !== 12'd40) begin
            failures++; $display("FAIL start_vcount: got %0d/%0d want 20/40", o_lane_vcount_l, o_lane_vcount_r);
        end
        checks++; if (o_plate_done !== 1'b0) begin failures++; $display("FAIL start_done: got %b want 0", o_plate_done); end
        for (int g = 0; g < 4; g++) begin
            logic [GW-1:0] ng;
            ng = GW'((g + 1) % 4);
            load_lanes(g, 1, 1'b0);
            ev();
            commit(g);
            checks++; if (o_group !== ng) begin failures++; $display("FAIL pass1_group%0d: got %0d want %0d", g, o_group, ng); end
            checks++; if (o_plate_done !== (g == 3)) begin failures++; $display("FAIL pass1_done%0d: got %b want %b", g, o_plate_done, g == 3); end
            checks++; if (o_char_valid !== exp_valid) begin failures++; $display("FAIL pass1_valid%0d: got %h want %h", g, o_char_valid, exp_valid); end
            checks++; if (o_lane_hcount_l !== win_l(int'(ng))) begin
                failures++; $display("FAIL pass1_win%0d: got %h want %h", g, o_lane_hcount_l, win_l(int'(ng)));
            end
        end
        checks++; if (o_char_bus !== exp_bus()) begin failures++; $display("FAIL pass1_bus: got %h want %h", o_char_bus, exp_bus()); end
        checks++; if (o_char_valid !== 8'hFF) begin failures++; $display("FAIL pass1_valid_all: got %h want ff", o_char_valid); end
        checks++; if (o_plate_stable !== 1'b0) begin failures++; $display("FAIL pass1_stable: got %b want 0", o_plate_stable); end
        checks++; if (o_lane_active !== 1'b1) begin failures++; $display("FAIL pass1_restart_active: got %b want 1", o_lane_active); end
        @(posedge pixelclk);
        #1;
        checks++; if (o_plate_done !== 1'b0) begin failures++; $display("FAIL done_width: got %b want 0", o_plate_done); end
    endtask

    task automatic test_stable();
        for (int g = 0; g < 4; g++) begin
            load_lanes(g, 1, 1'b0);
            ev();
            commit(g);
        end
        checks++; if (o_plate_stable !== STB) begin failures++; $display("FAIL pass2_stable: got %b want %b", o_plate_stable, STB); end
        checks++; if (o_plate_done !== 1'b1) begin failures++; $display("FAIL pass2_done: got %b want 1", o_plate_done); end
        for (int g = 0; g < 4; g++) begin
            load_lanes(g, 1, 1'b1);
            ev();
            commit(g);
            if (g == 0) begin
                checks++; if (o_plate_stable !== STB) begin failures++; $display("FAIL pass3_stable_hold: got %b want %b", o_plate_stable, STB); end
            end
        end
        checks++; if (o_plate_stable !== 1'b0) begin failures++; $display("FAIL pass3_stable: got %b want 0", o_plate_stable); end
        checks++; if (o_char_bus !== exp_bus()) begin failures++; $display("FAIL pass3_bus: got %h want %h", o_char_bus, exp_bus()); end
    endtask

    task automatic test_snapshot();
        i_hcount_l_bus[2*XW +: XW] = 12'd300;
        load_lanes(0, 1, 1'b1);
        ev();
        commit(0);
        checks++; if (o_lane_hcount_l[XW-1:0] !== 12'd100) begin failures++; $display("FAIL snap_hold: got %0d want 100", o_lane_hcount_l[XW-1:0]); end
        for (int g = 1; g < 4; g++) begin
            load_lanes(g, 1, 1'b1);
            ev();
            commit(g);
        end
        checks++; if (o_plate_stable !== STB) begin failures++; $display("FAIL pass4_stable: got %b want %b", o_plate_stable, STB); end
        load_lanes(0, 1, 1'b1);
        ev();
        commit(0);
        checks++; if (o_lane_hcount_l[XW-1:0] !== 12'd300) begin failures++; $display("FAIL snap_new: got %0d want 300", o_lane_hcount_l[XW-1:0]); end
        checks++; if (o_group !== 2'd1) begin failures++; $display("FAIL snap_group: got %0d want 1", o_group); end
    endtask

    task automatic test_abort();
        logic [NL*XW-1:0] held_win;
        held_win = {hl(3), 12'd300};
        i_enable = 1'b0;
        load_lanes(1, 9, 1'b0);
        ev();
        checks++; if (o_lane_active !== 1'b0) begin failures++; $display("FAIL abort_active: got %b want 0", o_lane_active); end
        checks++; if (o_char_bus !== exp_bus()) begin failures++; $display("FAIL abort_bus: got %h want %h", o_char_bus, exp_bus()); end
        checks++; if (o_char_valid !== exp_valid) begin failures++; $display("FAIL abort_valid: got %h want %h", o_char_valid, exp_valid); end
        checks++; if (o_plate_stable !== 1'b0) begin failures++; $display("FAIL abort_stable: got %b want 0", o_plate_stable); end
        checks++; if (o_plate_done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b want 0", o_plate_done); end
        checks++; if (o_lane_hcount_l !== held_win) begin failures++; $display("FAIL abort_win_hold: got %h want %h", o_lane_hcount_l, held_win); end
        // Enable toggled only between events must not start a pass
        i_enable = 1'b1;
        repeat (3) @(posedge pixelclk);
        i_enable = 1'b0;
        ev();
        checks++; if (o_lane_active !== 1'b0) begin failures++; $display("FAIL idle_en0: got %b want 0", o_lane_active); end
        i_enable = 1'b1;
        i_bounds_valid = 1'b0;
        ev();
        checks++; if (o_lane_active !== 1'b0) begin failures++; $display("FAIL idle_bv0: got %b want 0", o_lane_active); end
        i_bounds_valid = 1'b1;
        set_bounds();
        ev();
        checks++; if (o_lane_active !== 1'b1 || o_group !== 2'd0) begin
            failures++; $display("FAIL idle_start: got active=%b group=%0d want active=1 group=0", o_lane_active, o_group);
        end
        checks++; if (o_lane_hcount_l !== win_l(0)) begin failures++; $display("FAIL idle_start_win: got %h want %h", o_lane_hcount_l, win_l(0)); end
    endtask

    task automatic test_reset_mid();
        load_lanes(0, 4, 1'b0);
        ev();
        load_lanes(1, 4, 1'b0);
        ev();
        checks++; if (o_group !== 2'd2) begin failures++; $display("FAIL mid_group: got %0d want 2", o_group); end
        @(negedge pixelclk);
        reset_n = 1'b0;
        #1;
        clear_model();
        checks++; if (o_char_valid !== '0 || o_group !== 2'd0) begin
            failures++; $display("FAIL mid_reset: got valid=%h group=%0d want valid=0 group=0", o_char_valid, o_group);
        end
        checks++; if (o_lane_active !== 1'b0) begin failures++; $display("FAIL mid_reset_active: got %b want 0", o_lane_active); end
        repeat (3) @(posedge pixelclk);
        @(negedge pixelclk);
        reset_n = 1'b1;
        repeat (3) @(posedge pixelclk);
        #1;
        checks++; if (o_lane_active !== 1'b0) begin failures++; $display("FAIL vs_high_release: got active=%b want 0", o_lane_active); end
        ev();
        checks++; if (o_lane_active !== 1'b1 || o_group !== 2'd0 || o_char_valid !== '0) begin
            failures++; $display("FAIL post_reset_start: got active=%b group=%0d valid=%h want 1/0/00",
                                 o_lane_active, o_group, o_char_valid);
        end
        for (int g = 0; g < 4; g++) begin
            load_lanes(g, 5, 1'b0);
            ev();
            commit(g);
        end
        checks++; if (o_char_bus !== exp_bus() || o_char_valid !== 8'hFF) begin
            failures++; $display("FAIL post_reset_pass: got %h/%h want %h/ff", o_char_bus, o_char_valid, exp_bus());
        end
        checks++; if (o_plate_done !== 1'b1 || o_plate_stable !== 1'b0) begin
            failures++; $display("FAIL post_reset_end: got done=%b stable=%b want 1/0", o_plate_done, o_plate_stable);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_stable();
        test_snapshot();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
